// File: rtl/sweep_ctrl_pkg.sv
// Shared types and default sizes for the up/down sweep controller.
// The dwell states are only reachable when SWEEP_DWELL_EN is defined.
package sweep_ctrl_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int SWEEP_W_DEF = 8;
    localparam int DWELL_W_DEF = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        UP       = 3'd1,
        DOWN     = 3'd2,
        DWELL_HI = 3'd3,
        DWELL_LO = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/updown_sweep_ctrl_if.sv
// Command/status bundle between the register side and the sweep controller.
// The dwell field exists only when SWEEP_DWELL_EN is defined.
interface updown_sweep_ctrl_if
    import sweep_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SWEEP_W = SWEEP_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
);
    logic               start;
    logic               stop;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   hi;
    logic [SWEEP_W-1:0] n_sweeps;
`ifdef SWEEP_DWELL_EN
    logic [DWELL_W-1:0] dwell;
`endif
    logic [WIDTH-1:0]   out;
    logic               up;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, stop, lo, hi, n_sweeps,
`ifdef SWEEP_DWELL_EN
        output dwell,
`endif
        input  out, up, busy, done, err
    );

    modport slave (
        input  start, stop, lo, hi, n_sweeps,
`ifdef SWEEP_DWELL_EN
        input  dwell,
`endif
        output out, up, busy, done, err
    );

endinterface

// File: rtl/sweep_counter_core.sv
// Loadable WIDTH-bit up/down counter; the count register is the sweep output.
module sweep_counter_core
    import sweep_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    // count register: load wins over enable, otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= {WIDTH{1'b0}};
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            if (up) begin
                q <= q + WIDTH'(1);
            end else begin
                q <= q - WIDTH'(1);
            end
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer driving sweep_counter_core between latched bounds.
// Optional turnaround dwell is compiled in with SWEEP_DWELL_EN.
module updown_sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SWEEP_W = SWEEP_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_sweep_ctrl_if.slave   bus
);

    state_t             state_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   hi_r;
    logic [SWEEP_W-1:0] n_sweeps_r;
    logic [SWEEP_W-1:0] sweep_cnt_r;
    logic               up_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
`ifdef SWEEP_DWELL_EN
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] dwell_cnt_r;
`endif

    logic [WIDTH-1:0]   cnt_s;
    logic               load_s;
    logic               en_s;
    logic               dir_s;
    logic               at_hi_s;
    logic               at_lo_s;
    logic               last_sweep_s;

    sweep_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .en       (en_s),
        .up       (dir_s),
        .load_val (bus.lo),
        .q        (cnt_s)
    );

    // counter controls and bound detection for the current state
    always_comb begin
        load_s       = 1'b0;
        en_s         = 1'b0;
        dir_s        = up_r;
        at_hi_s      = ((cnt_s + WIDTH'(1)) == hi_r);
        at_lo_s      = ((cnt_s - WIDTH'(1)) == lo_r);
        last_sweep_s = (n_sweeps_r != {SWEEP_W{1'b0}}) &&
                       ((sweep_cnt_r + SWEEP_W'(1)) == n_sweeps_r);
        case (state_r)
            IDLE: begin
                if (bus.start && !bus.stop && (bus.lo < bus.hi)) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            UP: begin
                if (!bus.stop) begin
                    en_s  = 1'b1;
                    dir_s = 1'b1;
                end else begin
                    en_s  = 1'b0;
                end
            end
            DOWN: begin
                if (!bus.stop) begin
                    en_s  = 1'b1;
                    dir_s = 1'b0;
                end else begin
                    en_s  = 1'b0;
                end
            end
            default: begin
                en_s = 1'b0;
            end
        endcase
    end

    // sequencing FSM with registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            lo_r        <= {WIDTH{1'b0}};
            hi_r        <= {WIDTH{1'b0}};
            n_sweeps_r  <= {SWEEP_W{1'b0}};
            sweep_cnt_r <= {SWEEP_W{1'b0}};
            up_r        <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
`ifdef SWEEP_DWELL_EN
            dwell_r     <= {DWELL_W{1'b0}};
            dwell_cnt_r <= {DWELL_W{1'b0}};
`endif
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.stop) begin
                        state_r <= IDLE;
                    end else if (bus.start) begin
                        if (bus.lo < bus.hi) begin
                            lo_r        <= bus.lo;
                            hi_r        <= bus.hi;
                            n_sweeps_r  <= bus.n_sweeps;
                            sweep_cnt_r <= {SWEEP_W{1'b0}};
                            up_r        <= 1'b1;
                            busy_r      <= 1'b1;
                            state_r     <= UP;
`ifdef SWEEP_DWELL_EN
                            dwell_r     <= bus.dwell;
`endif
                        end else begin
                            err_r <= 1'b1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                UP: begin
                    if (bus.stop) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (at_hi_s) begin
                        up_r <= 1'b0;
`ifdef SWEEP_DWELL_EN
                        if (dwell_r != {DWELL_W{1'b0}}) begin
                            dwell_cnt_r <= dwell_r;
                            state_r     <= DWELL_HI;
                        end else begin
                            state_r     <= DOWN;
                        end
`else
                        state_r <= DOWN;
`endif
                    end else begin
                        state_r <= UP;
                    end
                end
                DOWN: begin
                    if (bus.stop) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (at_lo_s) begin
                        // saturate so continuous mode never wraps back onto n_sweeps
                        if (sweep_cnt_r != {SWEEP_W{1'b1}}) begin
                            sweep_cnt_r <= sweep_cnt_r + SWEEP_W'(1);
                        end else begin
                            sweep_cnt_r <= sweep_cnt_r;
                        end
                        if (last_sweep_s) begin
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            up_r <= 1'b1;
`ifdef SWEEP_DWELL_EN
                            if (dwell_r != {DWELL_W{1'b0}}) begin
                                dwell_cnt_r <= dwell_r;
                                state_r     <= DWELL_LO;
                            end else begin
                                state_r     <= UP;
                            end
`else
                            state_r <= UP;
`endif
                        end
                    end else begin
                        state_r <= DOWN;
                    end
                end
`ifdef SWEEP_DWELL_EN
                DWELL_HI, DWELL_LO: begin
                    if (bus.stop) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else if (dwell_cnt_r == DWELL_W'(1)) begin
                        state_r <= (state_r == DWELL_HI) ? DOWN : UP;
                    end else begin
                        dwell_cnt_r <= dwell_cnt_r - DWELL_W'(1);
                    end
                end
`endif
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.out  = cnt_s;
    assign bus.up   = up_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl; the dwell case runs only with SWEEP_DWELL_EN.
module tb_updown_sweep_ctrl;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    int   exp1_out  [7] = '{2, 3, 4, 5, 4, 3, 2};
    int   exp1_up   [7] = '{1, 1, 1, 0, 0, 0, 0};
    int   exp1_done [7] = '{0, 0, 0, 0, 0, 0, 1};
    int   exp4_out  [5] = '{1, 2, 1, 2, 1};
    int   exp4_up   [5] = '{1, 0, 1, 0, 0};
    int   exp5_out  [5] = '{3, 4, 5, 4, 3};
`ifdef SWEEP_DWELL_EN
    int   exp6_out  [7] = '{1, 2, 3, 3, 3, 2, 1};
`endif

    updown_sweep_ctrl_if #(.WIDTH(16), .SWEEP_W(8), .DWELL_W(4)) bus ();

    updown_sweep_ctrl #(.WIDTH(16), .SWEEP_W(8), .DWELL_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        int tri_v;
        int frozen;
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.lo       = 16'd0;
        bus.hi       = 16'd0;
        bus.n_sweeps = 8'd0;
`ifdef SWEEP_DWELL_EN
        bus.dwell    = 4'd0;
`endif
        step();
        step();
        chk("rst_out",  32'(bus.out),  32'd0);
        chk("rst_up",   32'(bus.up),   32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err",  32'(bus.err),  32'd0);
        reset = 1'b0;
        step();

        // basic single sweep 2..5..2
        bus.lo = 16'd2; bus.hi = 16'd5; bus.n_sweeps = 8'd1; bus.start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            bus.start = 1'b0;
            chk("t1_out",  32'(bus.out),  32'(exp1_out[i]));
            chk("t1_up",   32'(bus.up),   32'(exp1_up[i]));
            chk("t1_done", 32'(bus.done), 32'(exp1_done[i]));
            chk("t1_busy", 32'(bus.busy), 32'd1);
        end
        step();
        chk("t1_busy_end", 32'(bus.busy), 32'd0);
        chk("t1_done_end", 32'(bus.done), 32'd0);
        chk("t1_out_end",  32'(bus.out),  32'd2);

        // rejected start lo == hi
        bus.lo = 16'd5; bus.hi = 16'd5; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t2_err",  32'(bus.err),  32'd1);
        chk("t2_busy", 32'(bus.busy), 32'd0);
        chk("t2_out",  32'(bus.out),  32'd2);
        step();
        chk("t2_err_clr", 32'(bus.err),  32'd0);
        chk("t2_busy2",   32'(bus.busy), 32'd0);

        // stop and start together: stop wins
        bus.lo = 16'd7; bus.hi = 16'd9; bus.start = 1'b1; bus.stop = 1'b1;
        step();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("t2b_busy", 32'(bus.busy), 32'd0);
        chk("t2b_out",  32'(bus.out),  32'd2);
        chk("t2b_err",  32'(bus.err),  32'd0);

        // continuous triangle 0..3, period 6, then stop
        bus.lo = 16'd0; bus.hi = 16'd3; bus.n_sweeps = 8'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t3_load", 32'(bus.out), 32'd0);
        frozen = 0;
        for (int t = 1; t <= 20; t++) begin
            step();
            tri_v  = ((t % 6) <= 3) ? (t % 6) : (6 - (t % 6));
            frozen = tri_v;
            chk("t3_out",  32'(bus.out),  32'(tri_v));
            chk("t3_done", 32'(bus.done), 32'd0);
        end
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("t3_stop_out",  32'(bus.out),  32'(frozen));
        chk("t3_stop_busy", 32'(bus.busy), 32'd0);
        chk("t3_stop_done", 32'(bus.done), 32'd0);
        step();
        chk("t3_hold_out",  32'(bus.out),  32'(frozen));
        chk("t3_hold_done", 32'(bus.done), 32'd0);

        // asynchronous reset mid-run at out=4
        bus.lo = 16'd2; bus.hi = 16'd6; bus.n_sweeps = 8'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        chk("t4_pre_out", 32'(bus.out), 32'd4);
        reset = 1'b1;
        #1;
        chk("t4_rst_out",  32'(bus.out),  32'd0);
        chk("t4_rst_up",   32'(bus.up),   32'd1);
        chk("t4_rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        // restart after reset with a one-step span, two sweeps
        bus.lo = 16'd1; bus.hi = 16'd2; bus.n_sweeps = 8'd2; bus.start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            bus.start = 1'b0;
            chk("t4_out", 32'(bus.out), 32'(exp4_out[i]));
            chk("t4_up",  32'(bus.up),  32'(exp4_up[i]));
            chk("t4_done", 32'(bus.done), (i == 4) ? 32'd1 : 32'd0);
        end
        step();
        chk("t4_busy_end", 32'(bus.busy), 32'd0);

        // start while busy with new bounds is ignored
        bus.lo = 16'd3; bus.hi = 16'd5; bus.n_sweeps = 8'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t5_out0", 32'(bus.out), 32'(exp5_out[0]));
        bus.lo = 16'd10; bus.hi = 16'd20; bus.start = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            bus.start = 1'b0;
            chk("t5_out",  32'(bus.out),  32'(exp5_out[i]));
            chk("t5_done", 32'(bus.done), (i == 4) ? 32'd1 : 32'd0);
            chk("t5_err",  32'(bus.err),  32'd0);
        end
        step();
        chk("t5_busy_end", 32'(bus.busy), 32'd0);
        chk("t5_out_end",  32'(bus.out),  32'd3);

`ifdef SWEEP_DWELL_EN
        // dwell of 2 at each turnaround
        bus.lo = 16'd1; bus.hi = 16'd3; bus.n_sweeps = 8'd1; bus.dwell = 4'd2; bus.start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            bus.start = 1'b0;
            chk("t6_out",  32'(bus.out),  32'(exp6_out[i]));
            chk("t6_done", 32'(bus.done), (i == 6) ? 32'd1 : 32'd0);
        end
        step();
        chk("t6_busy_end", 32'(bus.busy), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
